// File: rtl/multiply_divide_unit.sv
// rtl/multiply_divide_unit.sv - iterative radix-2 multiply / restoring divide unit
`timescale 1ns/1ps
module multiply_divide_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic               sign1_q, sign1_d;
    logic               sign2_q, sign2_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   out_q, out_d;

    logic               in_sign1, in_sign2, div_by_zero, div_ovf;
    logic [WIDTH-1:0]   mag1, mag2, fast_res;

    always_comb begin
        in_sign1 = ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM))
                   && in1[WIDTH-1];
        in_sign2 = ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM)) && in2[WIDTH-1];
        mag1 = in_sign1 ? -in1 : in1;
        mag2 = in_sign2 ? -in2 : in2;
        div_by_zero = op[2] && (in2 == '0);
        div_ovf = ((op == OP_DIV) || (op == OP_REM)) && (in1 == MIN_NEG) && (in2 == ALL_ONES);
        // op[1] separates REM/REMU from DIV/DIVU within the divide class
        if (div_by_zero) begin
            fast_res = op[1] ? in1 : ALL_ONES;
        end else begin
            fast_res = op[1] ? '0 : in1;
        end
    end

    // acc holds {upper product, multiplier} for multiply, {remainder, quotient} for divide
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, step_acc, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, res;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opb_q};
        if (div_diff[WIDTH]) begin
            div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
        step_acc = op_q[2] ? div_next : mul_next;
        prod_fix = (sign1_q ^ sign2_q) ? -step_acc : step_acc;
        quo_fix  = (sign1_q ^ sign2_q) ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
        rem_fix  = sign1_q ? -step_acc[2*WIDTH-1:WIDTH] : step_acc[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MUL:                       res = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              res = quo_fix;
            default:                      res = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sign1_d = sign1_q;
        sign2_d = sign2_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        out_d   = out_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_d    = op;
                        sign1_d = in_sign1;
                        sign2_d = in_sign2;
                        cnt_d   = CNT_W'(WIDTH);
                        if (div_by_zero || div_ovf) begin
                            out_d   = fast_res;
                            state_d = S_DONE;
                        end else begin
                            acc_d   = op[2] ? {{WIDTH{1'b0}}, mag1} : {{WIDTH{1'b0}}, mag2};
                            opb_d   = op[2] ? mag2 : mag1;
                            state_d = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    acc_d = step_acc;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        out_d   = res;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            sign1_q <= 1'b0;
            sign2_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sign1_q <= sign1_d;
            sign2_q <= sign2_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out       = out_q;
endmodule

// File: tb/tb_multiply_divide_unit.sv
// tb/tb_multiply_divide_unit.sv - randomized bench for multiply_divide_unit against an arithmetic model
`timescale 1ns/1ps
module tb_multiply_divide_unit;
    localparam int W = 32;
    localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]   op;
    logic [W-1:0] in1, in2, out;

    always #5 clk = ~clk;

    multiply_divide_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .in1(in1), .in2(in2),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    int checks = 0;
    int errors = 0;

    // expectations for the current cycle, set by the driver right after each rising edge
    bit           exp_ready, exp_valid, out_en, lit_en;
    logic [W-1:0] exp_out, exp_lit;

    function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint     sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == '0) return '1;
                if (a == MIN_NEG && b == '1) return a;
                return W'(sa / sb);
            end
            3'd5: return (b == '0) ? '1 : a / b;
            3'd6: begin
                if (b == '0) return a;
                if (a == MIN_NEG && b == '1) return '0;
                return W'(sa % sb);
            end
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
        if (out_en) chk("out_model", out, exp_out);
        if (lit_en && exp_valid) chk("out_literal", out, exp_lit);
    end

    task automatic step(input bit r, input bit v, input bit oe);
        exp_ready = r;
        exp_valid = v;
        out_en    = oe;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit le, input logic [W-1:0] lit, input int hold);
        bit fast;
        int lat;
        fast = o[2] && ((b == '0) || (((o == 3'd4) || (o == 3'd6)) && (a == MIN_NEG) && (b == '1)));
        lat  = fast ? 1 : W + 1;
        op = o; in1 = a; in2 = b; in_valid = 1'b1; out_ready = (hold == 0);
        lit_en = 1'b0;
        step(1, 0, 0);
        in_valid = 1'b0;
        exp_out  = model(o, a, b);
        exp_lit  = lit;
        lit_en   = le;
        for (int k = 1; k < lat; k++) step(0, 0, 0);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            op  = 3'($urandom_range(0, 7));
            in1 = $urandom;
            in2 = $urandom;
            step(0, 1, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(0, 1, 1);
        lit_en = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return MIN_NEG;
            3: return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; in1 = '0; in2 = '0;
        exp_out = '0; exp_lit = '0; lit_en = 1'b0;
        exp_ready = 1'b1; exp_valid = 1'b0; out_en = 1'b1;
        repeat (3) step(1, 0, 1);
        reset = 1'b0;
        repeat (2) step(1, 0, 1);

        run_op(3'd0, 32'd7,        32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2,         1, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFD, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFF, 0);
        run_op(3'd5, 32'd100,       32'd7,         1, 32'd14,        10);
        run_op(3'd7, 32'd100,       32'd7,         1, 32'd2,         0);
        run_op(3'd5, 32'd5,         32'd0,         1, 32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'd5,         32'd0,         1, 32'd5,         0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0,         0);

        for (int n = 0; n < 150; n++) begin
            int hold;
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 0, '0, hold);
            repeat ($urandom_range(0, 2)) step(1, 0, 0);
        end

        // flush while the result is waiting
        op = 3'd5; in1 = 32'd5; in2 = 32'd0; in_valid = 1'b1; out_ready = 1'b0;
        step(1, 0, 0);
        in_valid = 1'b0; exp_out = '1;
        step(0, 1, 1);
        flush = 1'b1;
        step(0, 1, 1);
        flush = 1'b0; out_ready = 1'b1;
        step(1, 0, 0);

        // flush in the fifth busy cycle, then flush with a same-cycle request in idle
        op = 3'd0; in1 = $urandom; in2 = $urandom; in_valid = 1'b1;
        step(1, 0, 0);
        in_valid = 1'b0;
        repeat (4) step(0, 0, 0);
        flush = 1'b1;
        step(0, 0, 0);
        flush = 1'b0;
        step(1, 0, 0);
        flush = 1'b1; in_valid = 1'b1; op = 3'd0; in1 = 32'd9; in2 = 32'd9;
        step(1, 0, 0);
        flush = 1'b0; in_valid = 1'b0;
        repeat (2) step(1, 0, 0);
        run_op(3'd0, 32'd3, 32'd4, 1, 32'd12, 0);

        // asynchronous reset in the middle of a divide
        op = 3'd4; in1 = 32'h1234_5678; in2 = 32'd3; in_valid = 1'b1;
        step(1, 0, 0);
        in_valid = 1'b0;
        repeat (10) step(0, 0, 0);
        reset = 1'b1; exp_out = '0;
        repeat (2) step(1, 0, 1);
        reset = 1'b0;
        repeat (W + 5) step(1, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multiply_divide_unit.md
# multiply_divide_unit

Iterative integer multiply/divide unit that extends the integer execute stage with multiply, high-product, divide and remainder operations. It works on WIDTH-bit operands: one radix-2 step per cycle for multiply, one restoring-division step per cycle for divide. Valid/ready handshakes on both sides let the execute stage stall while an operation is in flight. A synchronous flush lets a branch redirect or trap drop a pending result.

## Interface
- WIDTH, 32: operand and result width in bits; legal values are ≥ 4.
- CNT_W, $clog2(WIDTH+1): width of the iteration counter; derived, never overridden.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort; returns the unit to IDLE and discards any operation or result.
- in_valid  input  1  operation request.
- in_ready  output  1  high only in IDLE.
- op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in1  input  WIDTH  rs1 operand (multiplicand or dividend).
- in2  input  WIDTH  rs2 operand (multiplier or divisor).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  result.

## Operation
- States:
  - IDLE: in_ready=1.
  - BUSY: iterating.
  - DONE: out_valid=1.
- IDLE→BUSY on in_valid && in_ready. At acceptance the unit latches op, records the operand signs, and loads magnitudes:
  - in1 is signed for MULH, MULHSU, DIV and REM.
  - in2 is signed for MULH, DIV and REM.
  - The counter loads WIDTH.
- IDLE→DONE directly (fast path) for these cases:
  - Divide-class op with in2==0: DIV/DIVU give all ones; REM/REMU give in1.
  - DIV/REM with in1==100…0 and in2==all ones (signed overflow): DIV gives in1; REM gives 0.
- Multiply step, in BUSY: if the product register LSB is 1, add the multiplicand into the upper half. Then shift the 2·WIDTH+1-bit accumulator right by 1.
- Divide step, in BUSY:
  - Shift {remainder, quotient} left by 1.
  - Trial-subtract the divisor from the remainder.
  - On no borrow, keep the difference and set the quotient LSB.
- Each BUSY cycle decrements the counter. BUSY→DONE when the counter reaches 1, i.e. after exactly WIDTH steps.
- Sign fix-up is registered on the BUSY→DONE edge:
  - Product is negated if the operand signs differ; only sign-relevant ops apply.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
  - MUL returns the low WIDTH bits; MULH/MULHSU/MULHU return the high WIDTH bits.
- DONE→IDLE on out_ready. out and out_valid hold stable while out_ready=0.
- flush has priority over every transition: next state is IDLE, out_valid=0, and any same-cycle in_valid is ignored.
- reset has priority over flush.
- Arithmetic is modulo 2^WIDTH (2^(2·WIDTH) for the full product). No exceptions are raised.

## Timing
- Reset values:
  - state IDLE, so in_ready=1.
  - out_valid=0.
  - out=0.
  - Counter and accumulators 0.
- Normal latency: with acceptance in cycle 0, out_valid is high in cycle WIDTH+1.
- Fast-path latency: with acceptance in cycle 0, out_valid is high in cycle 1.
- in_ready is low in BUSY and DONE. No new operation is accepted in the cycle the result is consumed.
- Best-case throughput is one operation per WIDTH+2 cycles.
- Reset asserted mid-operation clears all state immediately and asynchronously. No output appears after reset deasserts.
- Outputs are registered; no input reaches an output combinationally.
- in_ready is decoded from the state register.

## Test plan
All cases use WIDTH=32.
- MUL 7 × 0xFFFFFFFD → out 0xFFFFFFEB. out_valid rises exactly 33 cycles after acceptance. in_ready is low for the whole operation.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- Fast path, each with out_valid in cycle 1:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. out stays constant and in_valid is not accepted. out_ready=1 gives in_ready=1 in the following cycle.
- Abort and reset:
  - flush in BUSY cycle 5 → IDLE next cycle with no out_valid; a following MUL 3 × 4 → 12.
  - reset asserted mid-divide → out_valid=0 and out=0 immediately.
